// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared types and default geometry for the LED matrix scan stage.
//   scan_state_t : row FSM state (dark gap vs. row lit)
//   ROWS, COLS   : default matrix geometry
//   BOARD_W      : width of the life-board vector (ROWS*COLS)
//   clog2_min1   : $clog2 that never returns 0, so 1-deep counters still
//                  get a legal 1-bit register
// ---------------------------------------------------------------------------
package scan_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int BOARD_W = ROWS * COLS;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/led_matrix_scan_frame_divider.sv
// ---------------------------------------------------------------------------
// frame_divider
// Counts frame-end strobes and emits a one-cycle step_tick every GEN_FRAMES
// strobes. Shares clock, reset and enable behaviour with the scan top:
// enable=0 clears the count so a re-enabled display never fires a stale tick.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   enable     in  1 = count, 0 = count held at zero, no tick
//   frame_end  in  one-cycle strobe, one per completed frame
//   step_tick  out registered one-cycle pulse every GEN_FRAMES strobes
// ---------------------------------------------------------------------------
module frame_divider #(
  parameter int GEN_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic frame_end,
  output logic step_tick
);

  localparam int FW = scan_pkg::clog2_min1(GEN_FRAMES + 1);
  localparam logic [FW-1:0] GEN_TARGET = FW'(GEN_FRAMES);

  logic [FW-1:0] r_cnt;
  logic [FW-1:0] w_cnt_inc;
  logic          r_step_tick;

  assign w_cnt_inc = r_cnt + FW'(1);
  assign step_tick = r_step_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_step_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt       <= '0;
      r_step_tick <= 1'b0;
    end else if (frame_end) begin
      if (w_cnt_inc == GEN_TARGET) begin
        r_cnt       <= '0;
        r_step_tick <= 1'b1;
      end else begin
        r_cnt       <= w_cnt_inc;
        r_step_tick <= 1'b0;
      end
    end else begin
      r_step_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
// Scans the 64-bit life board onto an 8x8 LED matrix one row at a time,
// with a dark gap before each row to suppress ghosting. The board is latched
// only at frame start so a generation never tears across a frame, and a
// step_tick is emitted every GEN_FRAMES frames to advance the game stage.
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-low reset
//   enable      in  1 = scan; 0 = dark, counters held at frame start
//   board       in  live board; bit r*COLS+c = row r, column c
//   row_n       out row select, active-low, one-cold when lit
//   col         out column drive, active-high
//   frame_start out one-cycle pulse when the board is latched
//   step_tick   out one-cycle pulse once per GEN_FRAMES frames
//   dbg_state   out current row FSM state
// Handshake: none; enable is a level, pulses are single-cycle strobes with
// no back-pressure.
// ---------------------------------------------------------------------------
module led_matrix_scan #(
  parameter int ROWS       = scan_pkg::ROWS,
  parameter int COLS       = scan_pkg::COLS,
  parameter int DWELL      = 1250,
  parameter int BLANK      = 16,
  parameter int GEN_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ROWS*COLS-1:0]      board,
  output logic [ROWS-1:0]           row_n,
  output logic [COLS-1:0]           col,
  output logic                      frame_start,
  output logic                      step_tick,
  output scan_pkg::scan_state_t     dbg_state
);

  import scan_pkg::scan_state_t;
  import scan_pkg::S_BLANK;
  import scan_pkg::S_ON;

  localparam int BOARD_W = ROWS * COLS;
  localparam int CW = scan_pkg::clog2_min1((DWELL > BLANK) ? DWELL : BLANK);
  localparam int IW = scan_pkg::clog2_min1(ROWS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] ROW_LAST   = IW'(ROWS - 1);

  scan_state_t       r_state, w_state_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [IW-1:0]     r_idx, w_idx_d;
  logic              r_run;          // 0 until the first enabled edge
  logic [BOARD_W-1:0] r_fbuf;
  logic [ROWS-1:0]   r_row_n, w_row_n_d;
  logic [COLS-1:0]   r_col, w_col_d;
  logic              r_frame_start;
  logic              w_latch;
  logic              w_frame_last;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_run   <= 1'b0;
    end else if (!enable) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_run   <= 1'b1;
    end
  end

  // Next-state logic. The first enabled edge is treated as entering the
  // row-0 gap, so it latches the board like any other frame boundary.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + CW'(1);
    w_idx_d   = r_idx;
    w_latch   = 1'b0;
    if (!r_run) begin
      w_state_d = S_BLANK;
      w_cnt_d   = '0;
      w_idx_d   = '0;
      w_latch   = 1'b1;
    end else begin
      case (r_state)
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_d = S_ON;
            w_cnt_d   = '0;
          end
        end
        S_ON: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_d = S_BLANK;
            w_cnt_d   = '0;
            w_idx_d   = (r_idx == ROW_LAST) ? '0 : r_idx + IW'(1);
            w_latch   = (r_idx == ROW_LAST);
          end
        end
        default: begin
          w_state_d = S_BLANK;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // Strobe on the edge that enters the final lit cycle of the last row, so
  // the registered step_tick lands in the same cycle as the row wrap decision
  // and the next frame_start follows one cycle later.
  assign w_frame_last = enable && (w_state_d == S_ON) &&
                        (w_idx_d == ROW_LAST) && (w_cnt_d == DWELL_LAST);

  // Output logic: next values for the output registers, taken from the next
  // state so the pins change on the same edge as the FSM. A latch edge always
  // enters S_BLANK, so r_fbuf is already current whenever a row is lit.
  always_comb begin
    w_row_n_d = '1;
    w_col_d   = '0;
    if (w_state_d == S_ON) begin
      w_row_n_d = ~(ROWS'(1) << w_idx_d);
      w_col_d   = r_fbuf[w_idx_d*COLS +: COLS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_n       <= '1;
      r_col         <= '0;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_row_n       <= '1;
      r_col         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_row_n       <= w_row_n_d;
      r_col         <= w_col_d;
      r_frame_start <= w_latch;
    end
  end

  // Frame buffer is held while disabled; only a frame boundary reloads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fbuf <= '0;
    end else if (enable && w_latch) begin
      r_fbuf <= board;
    end
  end

  frame_divider #(
    .GEN_FRAMES (GEN_FRAMES)
  ) u_frame_divider (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .frame_end (w_frame_last),
    .step_tick (step_tick)
  );

  assign row_n       = r_row_n;
  assign col         = r_col;
  assign frame_start = r_frame_start;
  assign dbg_state   = r_state;

endmodule
